// File: rtl/lane_render_sequencer.sv
// Display sequencer for the theremin-hero framebuffer. It clears the frame,
// waits for a start press, then draws the lanes enabled for each beat in order.
// It also handles pause, queues one beat that arrives while drawing, counts any
// further overruns, and defers an end-of-song until the current beat is drawn.
module lane_render_sequencer #(
    parameter int GRID_W    = 240,
    parameter int GRID_H    = 180,
    parameter int NUM_LANES = 4,
    parameter int LANE_BITS = 2,
    parameter int ADDR_W    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 beat_tick,
    input  logic                 song_done,
    input  logic [NUM_LANES-1:0] lane_mask,
    input  logic                 shape_done,
    output logic                 clear_load,
    output logic                 clear_write,
    output logic [ADDR_W-1:0]    clear_addr,
    output logic                 ready_for_song,
    output logic                 lane_load,
    output logic                 lane_start,
    output logic [LANE_BITS-1:0] lane_idx,
    output logic                 busy,
    output logic [7:0]           missed_beats,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        RST_WAIT   = 4'd0,
        CLR_LOAD   = 4'd1,
        CLR_WRITE  = 4'd2,
        IDLE       = 4'd3,
        START_WAIT = 4'd4,
        WAIT_BEAT  = 4'd5,
        LANE_SCAN  = 4'd6,
        LANE_LOAD  = 4'd7,
        LANE_DRAW  = 4'd8,
        LANE_WAIT  = 4'd9,
        PAUSED     = 4'd10
    } state_t;

    // The lane mask is held zero-padded to the full lane-index range, so any
    // lane_idx value selects a defined bit.
    localparam int                   MASK_W    = 1 << LANE_BITS;
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);
    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(NUM_LANES - 1);

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      clearAddr_q, clearAddr_d;
    logic [LANE_BITS-1:0]   laneIdx_q, laneIdx_d;
    logic [7:0]             missed_q, missed_d;
    logic                   pending_q, pending_d;
    logic                   doneLatch_q, doneLatch_d;
    logic [MASK_W-1:0]      maskReg_q, maskReg_d;

    // Register all sequencer state; reset drops everything back to RST_WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RST_WAIT;
            clearAddr_q <= '0;
            laneIdx_q   <= '0;
            missed_q    <= '0;
            pending_q   <= 1'b0;
            doneLatch_q <= 1'b0;
            maskReg_q   <= '0;
        end else begin
            state_q     <= state_d;
            clearAddr_q <= clearAddr_d;
            laneIdx_q   <= laneIdx_d;
            missed_q    <= missed_d;
            pending_q   <= pending_d;
            doneLatch_q <= doneLatch_d;
            maskReg_q   <= maskReg_d;
        end
    end

    // Next-state logic, Moore strobes, and beat/song bookkeeping while drawing.
    always_comb begin
        state_d        = state_q;
        clearAddr_d    = clearAddr_q;
        laneIdx_d      = laneIdx_q;
        missed_d       = missed_q;
        pending_d      = pending_q;
        doneLatch_d    = doneLatch_q;
        maskReg_d      = maskReg_q;
        clear_load     = 1'b0;
        clear_write    = 1'b0;
        ready_for_song = 1'b0;
        lane_load      = 1'b0;
        lane_start     = 1'b0;
        busy           = 1'b0;

        if (state_q == LANE_SCAN || state_q == LANE_LOAD ||
            state_q == LANE_DRAW || state_q == LANE_WAIT) begin
            if (beat_tick) begin
                if (!pending_q) begin
                    pending_d = 1'b1;
                end else if (missed_q != 8'hFF) begin
                    missed_d = missed_q + 8'd1;
                end
            end
            if (song_done) begin
                doneLatch_d = 1'b1;
            end
        end

        case (state_q)
            RST_WAIT: state_d = CLR_LOAD;
            CLR_LOAD: begin
                clear_load = 1'b1;
                busy       = 1'b1;
                state_d    = CLR_WRITE;
            end
            CLR_WRITE: begin
                clear_write = 1'b1;
                busy        = 1'b1;
                if (clearAddr_q == LAST_ADDR) begin
                    clearAddr_d = '0;
                    state_d     = IDLE;
                end else begin
                    clearAddr_d = clearAddr_q + 1'b1;
                    state_d     = CLR_LOAD;
                end
            end
            IDLE: begin
                if (start) state_d = START_WAIT;
            end
            START_WAIT: begin
                if (!start) begin
                    missed_d  = '0;
                    pending_d = 1'b0;
                    state_d   = WAIT_BEAT;
                end
            end
            WAIT_BEAT: begin
                ready_for_song = 1'b1;
                if (song_done || doneLatch_q) begin
                    pending_d   = 1'b0;
                    doneLatch_d = 1'b0;
                    state_d     = CLR_LOAD;
                end else if (pause) begin
                    state_d = PAUSED;
                end else if (beat_tick || pending_q) begin
                    maskReg_d = MASK_W'(lane_mask);
                    laneIdx_d = '0;
                    pending_d = beat_tick && pending_q;
                    state_d   = LANE_SCAN;
                end
            end
            LANE_SCAN: begin
                busy = 1'b1;
                if (maskReg_q[laneIdx_q]) begin
                    state_d = LANE_LOAD;
                end else if (laneIdx_q == LAST_LANE) begin
                    state_d = WAIT_BEAT;
                end else begin
                    laneIdx_d = laneIdx_q + 1'b1;
                end
            end
            LANE_LOAD: begin
                lane_load = 1'b1;
                busy      = 1'b1;
                state_d   = LANE_DRAW;
            end
            LANE_DRAW: begin
                lane_start = 1'b1;
                busy       = 1'b1;
                state_d    = LANE_WAIT;
            end
            LANE_WAIT: begin
                busy = 1'b1;
                if (shape_done) begin
                    if (laneIdx_q == LAST_LANE) begin
                        state_d = WAIT_BEAT;
                    end else begin
                        laneIdx_d = laneIdx_q + 1'b1;
                        state_d   = LANE_SCAN;
                    end
                end
            end
            PAUSED: begin
                if (song_done) begin
                    pending_d   = 1'b0;
                    doneLatch_d = 1'b0;
                    state_d     = CLR_LOAD;
                end else if (!pause) begin
                    state_d = WAIT_BEAT;
                end
            end
            default: state_d = RST_WAIT;
        endcase
    end

    assign clear_addr   = clearAddr_q;
    assign lane_idx     = laneIdx_q;
    assign missed_beats = missed_q;
    assign state        = state_q;

endmodule

// File: tb/tb_lane_render_sequencer.sv
// Bench for lane_render_sequencer on a 4x3 grid with four lanes: directed
// scenarios with literal expectations, then a long randomized run, all tracked
// by a cycle-level reference model of the sequencer's behaviour.
module tb_lane_render_sequencer;

    localparam int GW = 4, GH = 3, NL = 4, LB = 2, AW = 16, NPIX = GW * GH;

    logic clock = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0;
    logic beat_tick = 1'b0, song_done = 1'b0, shape_done = 1'b0;
    logic [NL-1:0] lane_mask = '0;
    logic clear_load, clear_write, ready_for_song, lane_load, lane_start, busy;
    logic [AW-1:0] clear_addr;
    logic [LB-1:0] lane_idx;
    logic [7:0] missed_beats;
    logic [3:0] state;

    int checks = 0, errors = 0, cycle = 0;
    int mState = 0, mAddr = 0, mLane = 0, mMissed = 0;
    bit mPending = 0, mDone = 0, modelValid = 0, autoDraw = 0;
    logic [NL-1:0] mMask = '0;
    int drawCnt = 0;
    int clearLog[$], clearCyc[$], startLog[$];

    lane_render_sequencer #(.GRID_W(GW), .GRID_H(GH), .NUM_LANES(NL), .LANE_BITS(LB), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .pause(pause), .beat_tick(beat_tick),
        .song_done(song_done), .lane_mask(lane_mask), .shape_done(shape_done),
        .clear_load(clear_load), .clear_write(clear_write), .clear_addr(clear_addr),
        .ready_for_song(ready_for_song), .lane_load(lane_load), .lane_start(lane_start),
        .lane_idx(lane_idx), .busy(busy), .missed_beats(missed_beats), .state(state));

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    task automatic checkOutput(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cycle, act, exp);
        end
    endtask

    // Reference behaviour: one step per clock edge, evaluated on the inputs at the edge.
    task automatic modelStep();
        if (reset) begin
            mState = 0; mAddr = 0; mLane = 0; mMissed = 0;
            mPending = 0; mDone = 0; mMask = '0; modelValid = 1;
            return;
        end
        if (mState >= 6 && mState <= 9) begin
            if (beat_tick) begin
                if (!mPending) mPending = 1;
                else if (mMissed < 255) mMissed++;
            end
            if (song_done) mDone = 1;
        end
        case (mState)
            0: mState = 1;
            1: mState = 2;
            2: if (mAddr == NPIX - 1) begin mAddr = 0; mState = 3; end
               else begin mAddr++; mState = 1; end
            3: if (start) mState = 4;
            4: if (!start) begin mMissed = 0; mPending = 0; mState = 5; end
            5: if (song_done || mDone) begin mPending = 0; mDone = 0; mState = 1; end
               else if (pause) mState = 10;
               else if (beat_tick || mPending) begin
                   mMask = lane_mask; mLane = 0; mPending = beat_tick && mPending; mState = 6;
               end
            6: if (mMask[mLane]) mState = 7;
               else if (mLane == NL - 1) mState = 5;
               else mLane++;
            7: mState = 8;
            8: mState = 9;
            9: if (shape_done) begin
                   if (mLane == NL - 1) mState = 5;
                   else begin mLane++; mState = 6; end
               end
            10: if (song_done) begin mPending = 0; mDone = 0; mState = 1; end
                else if (!pause) mState = 5;
            default: mState = 0;
        endcase
    endtask

    // Advance the model at each edge, then compare every DUT output shortly after.
    always @(posedge clock) begin
        modelStep();
        cycle++;
        #2;
        if (modelValid) begin
            checkOutput("state", int'(state), mState);
            checkOutput("clear_load", int'(clear_load), int'(mState == 1));
            checkOutput("clear_write", int'(clear_write), int'(mState == 2));
            checkOutput("clear_addr", int'(clear_addr), mAddr);
            checkOutput("ready_for_song", int'(ready_for_song), int'(mState == 5));
            checkOutput("lane_load", int'(lane_load), int'(mState == 7));
            checkOutput("lane_start", int'(lane_start), int'(mState == 8));
            checkOutput("lane_idx", int'(lane_idx), mLane);
            checkOutput("busy", int'(busy), int'(mState inside {1, 2, 6, 7, 8, 9}));
            checkOutput("missed_beats", int'(missed_beats), mMissed);
            if (clear_write) begin clearLog.push_back(int'(clear_addr)); clearCyc.push_back(cycle); end
            if (lane_start) startLog.push_back(int'(lane_idx));
        end
    end

    // One cycle of stimulus: clear pulses at the falling edge and run the shape-drawer stand-in.
    task automatic applyStimulus();
        @(negedge clock);
        beat_tick = 0; song_done = 0; shape_done = 0;
        if (drawCnt > 0) begin
            drawCnt--;
            if (drawCnt == 0) shape_done = 1;
        end
        if (autoDraw && lane_start) drawCnt = 3;
    endtask

    task automatic waitState(int target, string name);
        int n = 0;
        do begin applyStimulus(); n++; end while (int'(state) != target && n < 300);
        checkOutput(name, int'(state), target);
    endtask

    task automatic checkLog(string name, int exp[$]);
        checkOutput({name, "_count"}, startLog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < startLog.size(); i++)
            checkOutput({name, "_lane"}, startLog[i], exp[i]);
    endtask

    initial begin
        int scan, n;
        // Test 1: clear after reset
        repeat (3) applyStimulus();
        reset = 0;
        clearLog.delete(); clearCyc.delete();
        waitState(3, "clear_to_idle");
        checkOutput("clear_writes", clearLog.size(), NPIX);
        for (int i = 0; i < NPIX && i < clearLog.size(); i++) begin
            checkOutput("clear_seq_addr", clearLog[i], i);
            if (i > 0) checkOutput("clear_spacing", clearCyc[i] - clearCyc[i-1], 2);
        end
        checkOutput("clear_addr_after", int'(clear_addr), 0);

        // Test 2: start press/release then a full-mask beat
        start = 1; applyStimulus(); start = 0; applyStimulus();
        checkOutput("start_to_wait", int'(state), 5);
        checkOutput("missed_start", int'(missed_beats), 0);
        lane_mask = 4'b1111; autoDraw = 1; startLog.delete();
        beat_tick = 1;
        waitState(5, "full_mask_done");
        checkLog("mask1111", '{0, 1, 2, 3});

        // Test 3: sparse and empty masks
        lane_mask = 4'b1010; startLog.delete(); beat_tick = 1;
        waitState(5, "mask1010_done");
        checkLog("mask1010", '{1, 3});
        lane_mask = 4'b0000; startLog.delete(); beat_tick = 1; scan = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (state == 4'd6) scan++;
            else if (state == 4'd5) break;
        end
        checkOutput("empty_scan_cycles", scan, 4);
        checkLog("mask0000", '{});

        // Test 4: overruns while a lane is drawing
        autoDraw = 0; lane_mask = 4'b0001; beat_tick = 1;
        waitState(9, "lane0_wait");
        for (int k = 0; k < 3; k++) begin beat_tick = 1; applyStimulus(); applyStimulus(); end
        checkOutput("missed_after_3", int'(missed_beats), 2);
        shape_done = 1;
        waitState(5, "back_to_wait");
        applyStimulus();
        checkOutput("pending_rescan", int'(state), 6);
        waitState(9, "rescan_lane0_wait");
        for (int k = 0; k < 300; k++) begin beat_tick = 1; applyStimulus(); end
        checkOutput("missed_saturated", int'(missed_beats), 255);
        autoDraw = 1; shape_done = 1;
        repeat (40) applyStimulus();
        checkOutput("drained_state", int'(state), 5);

        // Test 5: pause drops beats
        startLog.delete(); pause = 1; applyStimulus();
        checkOutput("paused_state", int'(state), 10);
        beat_tick = 1; applyStimulus(); applyStimulus();
        beat_tick = 1; applyStimulus(); applyStimulus();
        pause = 0; repeat (3) applyStimulus();
        checkLog("paused", '{});
        checkOutput("paused_missed", int'(missed_beats), 255);
        checkOutput("resume_state", int'(state), 5);

        // Test 6: deferred song_done, then reset in the middle of the clear
        autoDraw = 0; lane_mask = 4'b1111; beat_tick = 1;
        waitState(9, "t6_lane0");
        shape_done = 1;
        waitState(9, "t6_lane1");
        checkOutput("t6_lane_idx", int'(lane_idx), 1);
        startLog.delete(); song_done = 1; applyStimulus();
        autoDraw = 1; shape_done = 1;
        waitState(1, "t6_clear_begins");
        checkLog("after_song_done", '{2, 3});
        repeat (5) applyStimulus();
        n = clearLog.size();
        reset = 1; applyStimulus();
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_clear_write", int'(clear_write), 0);
        repeat (5) applyStimulus();
        checkOutput("no_writes_in_reset", clearLog.size(), n);
        reset = 0;

        // Randomized run against the model
        autoDraw = 0;
        for (int i = 0; i < 5000; i++) begin
            applyStimulus();
            start      = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            beat_tick  = ($urandom_range(0, 7) == 0);
            song_done  = ($urandom_range(0, 199) == 0);
            shape_done = ($urandom_range(0, 3) == 0);
            lane_mask  = NL'($urandom);
            reset      = ($urandom_range(0, 499) == 0);
        end
        applyStimulus(); applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
